cnt_timer_ctrl: RTL and testbench

- Controller that drives the load/hold interface of the team's 4-bit saturating down-counter (inputs pe, din; output q).
- Runs a programmable countdown: loads a duration, then lets the counter decrement once every DIV clocks and signals expiry.
- The counter has no count-enable, so this block holds it by re-loading its own value (pe=1, din=q) on every non-tick cycle.
- Sits between user controls (start, pause) and one counter instance.

---
 rtl/cnt_pkg.sv | 5 +
 rtl/cnt_tick_gen.sv | 20 ++
 rtl/cnt_timer_ctrl.sv | 55 +++++
 tb/tb_cnt_timer_ctrl.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/cnt_pkg.sv
// cnt_pkg: shared state encoding and counter width for the countdown timer
package cnt_pkg;
  localparam int CNT_W = 4;
  typedef enum logic [2:0] {IDLE, LOAD, RUN, PAUSE, DONE} state_t;
endpackage

// File: rtl/cnt_tick_gen.sv
// cnt_tick_gen: prescaler producing one tick every DIV enabled cycles
module cnt_tick_gen #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rstn,
  input  logic en,
  input  logic clr,
  output logic tick
);
  localparam int CW = DIV > 1 ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);
  logic [CW-1:0] cnt;
  assign tick = en && cnt == LAST;
  // count only while enabled, wrap on tick; clear wins, otherwise hold
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/cnt_timer_ctrl.sv
// cnt_timer_ctrl: drives a saturating down-counter's load/hold port to run a paced countdown
module cnt_timer_ctrl
  import cnt_pkg::*;
#(
  parameter int W   = CNT_W,
  parameter int DIV = 4
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         start,
  input  logic [W-1:0] dur,
  input  logic         pause,
  input  logic [W-1:0] cnt_q,
  output logic         cnt_pe,
  output logic [W-1:0] cnt_din,
  output logic         busy,
  output logic         done
);
  state_t state, nxt;
  logic [W-1:0] dur_r;
  logic tick, active, take, q_zero;
  state_t go_st;
  cnt_tick_gen #(.DIV(DIV)) u_tick (
    .clk (clk),
    .rstn(rstn),
    .en  (state == RUN),
    .clr (state == LOAD),
    .tick(tick)
  );
  assign active = state == RUN || state == PAUSE;
  assign take = start && (state == IDLE || active);
  assign q_zero = cnt_q == '0;
  assign go_st = dur != '0 ? LOAD : DONE;
  assign busy = state == LOAD || active;
  assign done = state == DONE;
  // the counter has no enable: hold it by reloading q except on tick cycles with q above zero
  assign cnt_pe = state == RUN ? (q_zero | ~tick) : 1'b1;
  assign cnt_din = state == LOAD ? dur_r : active ? cnt_q : '0;
  // start outranks expiry, which outranks pause
  always_comb begin
    nxt = take ? go_st :
          state == LOAD ? RUN :
          state == RUN ? (q_zero ? DONE : pause ? PAUSE : RUN) :
          state == PAUSE ? (pause ? PAUSE : RUN) : IDLE;
  end
  // state register and duration latch
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state <= IDLE;
      dur_r <= '0;
    end else begin
      state <= nxt;
      if (take) dur_r <= dur;
    end
endmodule

// File: tb/tb_cnt_timer_ctrl.sv
// tb_cnt_timer_ctrl: directed checks of the countdown controller against saturating counter models
module tb_cnt_timer_ctrl;
  logic clk = 0;
  logic rstn = 0;
  logic start = 0;
  logic [3:0] dur = 0;
  logic pause = 0;
  logic [3:0] q0, q1, din0, din1;
  logic pe0, pe1, busy0, busy1, done0, done1;
  logic s = 0;
  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  cnt_timer_ctrl #(.W(4), .DIV(4)) dut0 (
    .clk(clk), .rstn(rstn), .start(start), .dur(dur), .pause(pause),
    .cnt_q(q0), .cnt_pe(pe0), .cnt_din(din0), .busy(busy0), .done(done0)
  );
  cnt_timer_ctrl #(.W(4), .DIV(1)) dut1 (
    .clk(clk), .rstn(rstn), .start(start), .dur(dur), .pause(pause),
    .cnt_q(q1), .cnt_pe(pe1), .cnt_din(din1), .busy(busy1), .done(done1)
  );

  // saturating down-counters: load on pe, otherwise decrement and stick at zero
  always_ff @(posedge clk) begin
    q0 <= pe0 ? din0 : (q0 != 0 ? q0 - 4'd1 : 4'd0);
    q1 <= pe1 ? din1 : (q1 != 0 ? q1 - 4'd1 : 4'd0);
  end

  wire [3:0] oq   = s ? q1 : q0;
  wire [3:0] odin = s ? din1 : din0;
  wire       ope  = s ? pe1 : pe0;
  wire       obusy = s ? busy1 : busy0;
  wire       odone = s ? done1 : done0;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got == exp) passed++;
    else $display("FAIL %s got %0d expected %0d", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 0;
    step();
    step();
    rstn = 1;
    step();
  endtask

  task automatic go(input int d);
    start = 1;
    dur = 4'(d);
    step();
    start = 0;
    dur = 0;
  endtask

  function automatic int f(input int d, input int div, input int k);
    int v;
    v = d - (k - 1) / div;
    return v < 0 ? 0 : v;
  endfunction

  // after start was taken at E0, check edges E1..En; pause held from after E(pa) to after E(pa+pl)
  task automatic countdown(input string tag, input int d, input int div, input int pa, input int pl, input int n);
    int de, eq;
    de = d * div + 2 + pl;
    for (int k = 1; k <= n; k++) begin
      step();
      eq = k <= pa + 1 ? f(d, div, k) : k <= pa + pl + 1 ? f(d, div, pa + 1) : f(d, div, k - pl);
      chk($sformatf("%s q k=%0d", tag, k), oq, eq);
      chk($sformatf("%s done k=%0d", tag, k), odone, k == de);
      chk($sformatf("%s busy k=%0d", tag, k), obusy, k < de);
      if (div == 1) chk($sformatf("%s pe k=%0d", tag, k), ope, !(k >= 1 && k <= d));
      if (pl > 0 && k == pa) pause = 1;
      if (pl > 0 && k == pa + pl) pause = 0;
    end
  endtask

  initial begin
    #1;
    step();
    chk("rst busy", obusy, 0);
    chk("rst done", odone, 0);
    chk("rst pe", ope, 1);
    chk("rst din", odin, 0);
    rstn = 1;
    step();
    chk("idle q", oq, 0);
    chk("idle pe", ope, 1);

    go(3);
    countdown("basic", 3, 4, 0, 0, 16);

    do_reset();
    chk("zero pre pe", ope, 1);
    go(0);
    chk("zero done", odone, 1);
    chk("zero q", oq, 0);
    chk("zero pe", ope, 1);
    chk("zero busy", obusy, 0);
    step();
    chk("zero done2", odone, 0);
    chk("zero q2", oq, 0);
    chk("zero pe2", ope, 1);

    do_reset();
    go(5);
    countdown("pause", 5, 4, 10, 7, 31);

    do_reset();
    go(3);
    countdown("abort pre", 3, 4, 0, 0, 6);
    chk("abort q2", oq, 2);
    go(9);
    chk("abort load busy", obusy, 1);
    chk("abort load done", odone, 0);
    countdown("abort", 9, 4, 0, 0, 40);

    do_reset();
    go(5);
    countdown("rst pre", 5, 4, 0, 0, 6);
    chk("mid q4", oq, 4);
    rstn = 0;
    #1;
    chk("mid busy", obusy, 0);
    chk("mid pe", ope, 1);
    chk("mid din", odin, 0);
    chk("mid done", odone, 0);
    step();
    chk("mid q", oq, 0);
    rstn = 1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("mid post done %0d", k), odone, 0);
      chk($sformatf("mid post busy %0d", k), obusy, 0);
      chk($sformatf("mid post q %0d", k), oq, 0);
    end

    s = 1;
    do_reset();
    go(15);
    countdown("div1", 15, 1, 0, 0, 21);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
